// File: rtl/queue_writer.sv
// -----------------------------------------------------------------------------
// queue_writer
//
// Enqueue-side front end of the SRAM queue controller. Each ingress packet is
// classified by the priority field of its header beat and written into that
// priority's circular region of the shared SRAM. Space is reserved for the
// whole packet at the header. Packets that cannot be reserved are dropped
// whole. Completed packets are published to the scheduler, and the scheduler
// hands freed space back through the release port.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   in_vld/in_rdy     ingress beat handshake; in_sop/in_eop mark packet edges
//   in_data           beat payload; header: [2:0] qid, [10:4] length in words
//   sram_we/waddr/    registered SRAM write port; waddr = {qid, word pointer}
//   sram_wdata
//   rel_vld/rel_qid/  scheduler release of one packet and its word count
//   rel_words
//   q_pkt_cnt         committed packets per queue (queue q at slice q)
//   q_nonempty        per-queue committed-packet flag
//   drop_pulse        one pulse per rejected packet, the cycle after its header
//   len_err           one pulse in the commit cycle of an over-length packet
// -----------------------------------------------------------------------------
module queue_writer #(
    parameter int DATA_WIDTH  = 256,
    parameter int QUEUE_NUM   = 8,
    parameter int QUEUE_DEPTH = 64,
    localparam int QW = $clog2(QUEUE_NUM),
    localparam int PW = $clog2(QUEUE_DEPTH),
    localparam int CW = PW + 1,
    localparam int AW = QW + PW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_rdy,
    output logic                    sram_we,
    output logic [AW-1:0]           sram_waddr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic                    rel_vld,
    input  logic [QW-1:0]           rel_qid,
    input  logic [CW-1:0]           rel_words,
    output logic [QUEUE_NUM*CW-1:0] q_pkt_cnt,
    output logic [QUEUE_NUM-1:0]    q_nonempty,
    output logic                    drop_pulse,
    output logic                    len_err
);

    // Width of the header length field, and a compare width wide enough for
    // both the length and the occupancy so that their sum cannot wrap.
    localparam int LW = 7;
    localparam int XW = ((LW > CW) ? LW : CW) + 1;

    typedef enum logic [1:0] {IDLE, BODY, DROP, COMMIT} state_t;

    state_t state, state_nxt;

    // Per-queue bookkeeping: committed tail, reserved words, committed packets.
    logic [PW-1:0] wr_ptr      [QUEUE_NUM];
    logic [CW-1:0] used        [QUEUE_NUM];
    logic [CW-1:0] pkt_cnt     [QUEUE_NUM];
    logic [PW-1:0] wr_ptr_nxt  [QUEUE_NUM];
    logic [CW-1:0] used_nxt    [QUEUE_NUM];
    logic [CW-1:0] pkt_cnt_nxt [QUEUE_NUM];

    // Packet in progress.
    logic [QW-1:0] cur_qid;
    logic [CW-1:0] cur_len;
    logic [CW-1:0] cnt;
    logic          err_pend;

    logic          beat;
    logic [QW-1:0] hdr_qid;
    logic [LW-1:0] hdr_len;
    logic          rel_hit;
    logic [CW-1:0] used_eff;
    logic          fits;
    logic [PW-1:0] body_ptr;

    logic          admit;
    logic          reject;
    logic          commit;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          cnt_inc;
    logic          overflow;

    assign in_rdy   = rst && (state != COMMIT);
    assign beat     = in_vld && in_rdy;
    assign hdr_qid  = in_data[QW-1:0];
    assign hdr_len  = in_data[10:4];
    assign body_ptr = wr_ptr[cur_qid] + cnt[PW-1:0];
    assign len_err  = (state == COMMIT) && err_pend;

    // A release on an empty queue is meaningless and must not touch used[].
    assign rel_hit = rel_vld && (pkt_cnt[rel_qid] != '0);

    // Admission sees the space freed by a release landing in the same cycle.
    always_comb begin
        used_eff = used[hdr_qid];
        if (rel_hit && (rel_qid == hdr_qid)) begin
            used_eff = used[hdr_qid] - rel_words;
        end
    end

    assign fits = (hdr_len != '0) &&
                  ((XW'(hdr_len) + XW'(used_eff)) <= XW'(QUEUE_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        admit     = 1'b0;
        reject    = 1'b0;
        commit    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        cnt_inc   = 1'b0;
        overflow  = 1'b0;
        case (state)
            IDLE: begin
                if (beat && in_sop) begin
                    if (fits) begin
                        admit     = 1'b1;
                        wr_en     = 1'b1;
                        wr_addr   = {hdr_qid, wr_ptr[hdr_qid]};
                        state_nxt = in_eop ? COMMIT : BODY;
                    end else begin
                        reject    = 1'b1;
                        state_nxt = in_eop ? IDLE : DROP;
                    end
                end
            end
            BODY: begin
                if (beat) begin
                    // Beats beyond the header length are discarded, not
                    // written, so they can never spill into unreserved space.
                    if (cnt < cur_len) begin
                        wr_en   = 1'b1;
                        wr_addr = {cur_qid, body_ptr};
                        cnt_inc = 1'b1;
                    end else begin
                        overflow = 1'b1;
                    end
                    if (in_eop) begin
                        state_nxt = COMMIT;
                    end
                end
            end
            DROP: begin
                if (beat && in_eop) begin
                    state_nxt = IDLE;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Release, reservation and commit may hit the same queue in one cycle;
    // all contributions are summed so none is lost.
    always_comb begin
        for (int q = 0; q < QUEUE_NUM; q++) begin
            wr_ptr_nxt[q]  = wr_ptr[q];
            used_nxt[q]    = used[q];
            pkt_cnt_nxt[q] = pkt_cnt[q];
            if (rel_hit && (rel_qid == QW'(q))) begin
                used_nxt[q]    = used_nxt[q] - rel_words;
                pkt_cnt_nxt[q] = pkt_cnt_nxt[q] - CW'(1);
            end
            if (admit && (hdr_qid == QW'(q))) begin
                used_nxt[q] = used_nxt[q] + CW'(hdr_len);
            end
            if (commit && (cur_qid == QW'(q))) begin
                // Hand back the part of the reservation that was never written.
                used_nxt[q]    = used_nxt[q] - (cur_len - cnt);
                pkt_cnt_nxt[q] = pkt_cnt_nxt[q] + CW'(1);
                wr_ptr_nxt[q]  = wr_ptr[q] + cnt[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int q = 0; q < QUEUE_NUM; q++) begin
                wr_ptr[q]  <= '0;
                used[q]    <= '0;
                pkt_cnt[q] <= '0;
            end
        end else begin
            for (int q = 0; q < QUEUE_NUM; q++) begin
                wr_ptr[q]  <= wr_ptr_nxt[q];
                used[q]    <= used_nxt[q];
                pkt_cnt[q] <= pkt_cnt_nxt[q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_qid    <= '0;
            cur_len    <= '0;
            cnt        <= '0;
            err_pend   <= 1'b0;
            sram_we    <= 1'b0;
            sram_waddr <= '0;
            sram_wdata <= '0;
            drop_pulse <= 1'b0;
        end else begin
            sram_we    <= wr_en;
            drop_pulse <= reject;
            if (wr_en) begin
                sram_waddr <= wr_addr;
                sram_wdata <= in_data;
            end
            if (admit) begin
                cur_qid  <= hdr_qid;
                cur_len  <= CW'(hdr_len);
                cnt      <= CW'(1);
                err_pend <= 1'b0;
            end
            if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
            if (overflow) begin
                err_pend <= 1'b1;
            end
        end
    end

    for (genvar q = 0; q < QUEUE_NUM; q++) begin : g_status
        assign q_pkt_cnt[q*CW +: CW] = pkt_cnt[q];
        assign q_nonempty[q]         = (pkt_cnt[q] != '0);
    end

endmodule

// File: tb/tb_queue_writer.sv
// -----------------------------------------------------------------------------
// tb_queue_writer
//
// Drives packets and scheduler releases into queue_writer, keeps a
// packet-level reference model of queue occupancy, tails and committed packets,
// and pushes timestamped expectations into queues. A separate monitor compares
// the DUT outputs against those queues every cycle.
// -----------------------------------------------------------------------------
module tb_queue_writer;

    localparam int DW = 256;
    localparam int QN = 8;
    localparam int QD = 64;
    localparam int QW = 3;
    localparam int CW = 7;
    localparam int AW = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_vld = 1'b0;
    logic           in_sop = 1'b0;
    logic           in_eop = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_rdy;
    logic           sram_we;
    logic [AW-1:0]  sram_waddr;
    logic [DW-1:0]  sram_wdata;
    logic           rel_vld = 1'b0;
    logic [QW-1:0]  rel_qid = '0;
    logic [CW-1:0]  rel_words = '0;
    logic [QN*CW-1:0] q_pkt_cnt;
    logic [QN-1:0]  q_nonempty;
    logic           drop_pulse;
    logic           len_err;

    queue_writer #(.DATA_WIDTH(DW), .QUEUE_NUM(QN), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
        .in_rdy(in_rdy),
        .sram_we(sram_we), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .rel_vld(rel_vld), .rel_qid(rel_qid), .rel_words(rel_words),
        .q_pkt_cnt(q_pkt_cnt), .q_nonempty(q_nonempty),
        .drop_pulse(drop_pulse), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int cyc; logic v; } flag_t;
    typedef struct { int cyc; logic [QN*CW-1:0] cnt; logic [QN-1:0] ne; } cnt_t;

    wr_t   exp_wr[$];
    flag_t exp_rdy[$];
    cnt_t  exp_cnt[$];
    int    exp_drop[$];
    int    exp_lerr[$];

    // Reference model: per-queue reserved words, tail, committed packet sizes.
    int m_used[QN];
    int m_tail[QN];
    int m_words[QN][$];
    bit m_commit, m_inpkt, m_drop, m_err;
    int m_q, m_len, m_cnt;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int q = 0; q < QN; q++) begin
            m_used[q] = 0;
            m_tail[q] = 0;
            m_words[q].delete();
        end
        m_commit = 0; m_inpkt = 0; m_drop = 0; m_err = 0;
        m_q = 0; m_len = 0; m_cnt = 0;
        exp_wr.delete(); exp_rdy.delete(); exp_cnt.delete();
        exp_drop.delete(); exp_lerr.delete();
    endtask

    // One clock of the reference model, applied in the order the rules give:
    // release first, then commit or beat handling.
    task automatic step(input logic v, input logic s, input logic e, input logic [DW-1:0] d,
                        input logic rv, input int rq, input int rw, output logic acc);
        logic          rdy;
        int            q, len;
        logic [AW-1:0] a;
        cnt_t          c;
        rdy = !m_commit;
        exp_rdy.push_back('{cyc, rdy});
        acc = v && rdy;
        if (rv && m_words[rq].size() > 0) begin
            void'(m_words[rq].pop_front());
            m_used[rq] -= rw;
        end
        if (m_commit) begin
            m_tail[m_q] = (m_tail[m_q] + m_cnt) % QD;
            m_used[m_q] -= (m_len - m_cnt);
            m_words[m_q].push_back(m_cnt);
            if (m_err) exp_lerr.push_back(cyc);
            m_commit = 0;
        end else if (acc) begin
            if (m_inpkt) begin
                if (m_cnt < m_len) begin
                    a = AW'(m_q * QD + (m_tail[m_q] + m_cnt) % QD);
                    exp_wr.push_back('{cyc + 1, a, d});
                    m_cnt++;
                end else begin
                    m_err = 1;
                end
                if (e) begin
                    m_inpkt  = 0;
                    m_commit = 1;
                end
            end else if (m_drop) begin
                if (e) m_drop = 0;
            end else if (s) begin
                q   = int'(d[2:0]);
                len = int'(d[10:4]);
                if (len == 0 || len > QD - m_used[q]) begin
                    exp_drop.push_back(cyc + 1);
                    m_drop = !e;
                end else begin
                    m_used[q] += len;
                    a = AW'(q * QD + m_tail[q]);
                    exp_wr.push_back('{cyc + 1, a, d});
                    m_q = q; m_len = len; m_cnt = 1; m_err = 0;
                    if (e) m_commit = 1;
                    else   m_inpkt  = 1;
                end
            end
        end
        c.cyc = cyc + 1;
        for (int k = 0; k < QN; k++) begin
            c.cnt[k*CW +: CW] = CW'(m_words[k].size());
            c.ne[k]           = (m_words[k].size() != 0);
        end
        exp_cnt.push_back(c);
    endtask

    task automatic cycle(input logic v, input logic s, input logic e, input logic [DW-1:0] d,
                         input logic rv, input int rq, output logic acc);
        int rw;
        rw = (m_words[rq].size() > 0) ? m_words[rq][0] : int'($urandom_range(1, 8));
        in_vld = v; in_sop = s; in_eop = e; in_data = d;
        rel_vld = rv; rel_qid = QW'(rq); rel_words = CW'(rw);
        step(v, s, e, d, rv, rq, rw, acc);
        @(negedge clk);
    endtask

    task automatic send_beat(input logic s, input logic e, input logic [DW-1:0] d,
                             input logic rv, input int rq);
        logic acc;
        logic r;
        int   tries;
        r = rv;
        tries = 0;
        do begin
            cycle(1'b1, s, e, d, r, rq, acc);
            r = 1'b0;
            if (!acc) stalls++;
            tries++;
        end while (!acc && tries < 20);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout actual=not_accepted expected=accepted within 20 cycles");
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    // relmode 0: no releases; 1: release on queue rq with the header beat;
    // 2: random releases on random queues with every beat.
    task automatic send_pkt(input int q, input int len, input int nb, input int relmode, input int rq);
        logic [DW-1:0] d;
        logic          rv;
        int            rqq;
        for (int i = 0; i < nb; i++) begin
            d = rnd_word();
            if (i == 0) begin
                d[2:0]  = QW'(q);
                d[10:4] = 7'(len);
            end
            rv  = 1'b0;
            rqq = rq;
            if (relmode == 1 && i == 0) rv = 1'b1;
            if (relmode == 2) begin
                rv  = ($urandom_range(0, 2) == 0);
                rqq = $urandom_range(0, QN - 1);
            end
            send_beat(i == 0, i == nb - 1, d, rv, rqq);
        end
        in_vld = 1'b0;
        rel_vld = 1'b0;
    endtask

    task automatic idle(input int n, input bit rnd);
        logic acc;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, rnd && ($urandom_range(0, 2) == 0),
                  $urandom_range(0, QN - 1), acc);
        end
        rel_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_vld = 1'b0;
        rel_vld = 1'b0;
        model_clear();
        #1;
        chk("rst_in_rdy", 256'(in_rdy), 256'(0));
        chk("rst_sram_we", 256'(sram_we), 256'(0));
        chk("rst_sram_waddr", 256'(sram_waddr), 256'(0));
        chk("rst_sram_wdata", sram_wdata, '0);
        chk("rst_drop_pulse", 256'(drop_pulse), 256'(0));
        chk("rst_len_err", 256'(len_err), 256'(0));
        chk("rst_q_pkt_cnt", 256'(q_pkt_cnt), 256'(0));
        chk("rst_q_nonempty", 256'(q_nonempty), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compares DUT outputs with whatever the model scheduled for
    // this cycle, just after the falling edge.
    initial begin
        wr_t   w;
        flag_t f;
        cnt_t  c;
        logic  e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
                w = exp_wr.pop_front();
                chk("sram_we", 256'(sram_we), 256'(1));
                chk("sram_waddr", 256'(sram_waddr), 256'(w.addr));
                chk("sram_wdata", sram_wdata, w.data);
            end else if (sram_we) begin
                chk("sram_we_unexpected", 256'(sram_we), 256'(0));
            end
            e = (exp_drop.size() > 0 && exp_drop[0] == cyc);
            if (e) void'(exp_drop.pop_front());
            if (e || drop_pulse) chk("drop_pulse", 256'(drop_pulse), 256'(e));
            e = (exp_lerr.size() > 0 && exp_lerr[0] == cyc);
            if (e) void'(exp_lerr.pop_front());
            if (e || len_err) chk("len_err", 256'(len_err), 256'(e));
            if (exp_rdy.size() > 0 && exp_rdy[0].cyc == cyc) begin
                f = exp_rdy.pop_front();
                chk("in_rdy", 256'(in_rdy), 256'(f.v));
            end
            if (exp_cnt.size() > 0 && exp_cnt[0].cyc == cyc) begin
                c = exp_cnt.pop_front();
                chk("q_pkt_cnt", 256'(q_pkt_cnt), 256'(c.cnt));
                chk("q_nonempty", 256'(q_nonempty), 256'(c.ne));
            end
        end
    end

    initial begin
        int q, len, nb, r;
        model_clear();
        @(negedge clk);
        do_reset();

        // Single 4-word packet on priority 3: addresses 192..195.
        send_pkt(3, 4, 4, 0, 0);
        idle(2, 0);
        chk("t1_nonempty", 256'(q_nonempty), 256'(8'b0000_1000));
        chk("t1_cnt3", 256'(q_pkt_cnt[3*CW +: CW]), 256'(1));

        // Fill queue 0 exactly, then one more packet that must be dropped.
        for (int i = 0; i < 16; i++) send_pkt(0, 4, 4, 0, 0);
        send_pkt(0, 4, 4, 0, 0);
        idle(2, 0);
        chk("t2_cnt0_full", 256'(q_pkt_cnt[0 +: CW]), 256'(16));

        // Release on the full queue in the same cycle as a new header.
        send_pkt(0, 4, 4, 1, 0);
        idle(2, 0);
        chk("t3_cnt0_after_wrap", 256'(q_pkt_cnt[0 +: CW]), 256'(16));

        // Short and over-length packets on queue 1, then occupancy boundaries.
        send_pkt(1, 5, 3, 0, 0);
        send_pkt(1, 2, 4, 0, 0);
        send_pkt(1, 59, 59, 0, 0);
        send_pkt(1, 1, 1, 0, 0);
        send_pkt(4, 0, 2, 0, 0);
        send_pkt(4, 100, 1, 0, 0);
        send_pkt(4, 64, 64, 0, 0);
        idle(2, 0);
        chk("t4_cnt1", 256'(q_pkt_cnt[1*CW +: CW]), 256'(3));

        // Reset in the middle of an 8-word packet.
        send_beat(1'b1, 1'b0, {rnd_word()} & ~256'h7FF | 256'h082, 1'b0, 0);
        for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0, rnd_word(), 1'b0, 0);
        do_reset();
        send_pkt(2, 3, 3, 0, 0);
        idle(2, 0);
        chk("t5_cnt2_after_reset", 256'(q_pkt_cnt[2*CW +: CW]), 256'(1));

        // Back-to-back packets on queues 7 and 0: one commit stall between them.
        stalls = 0;
        send_pkt(7, 4, 4, 0, 0);
        send_pkt(0, 4, 4, 0, 0);
        idle(2, 0);
        chk("t6_stall_cycles", 256'(stalls), 256'(1));
        chk("t6_cnt7", 256'(q_pkt_cnt[7*CW +: CW]), 256'(1));
        chk("t6_cnt0", 256'(q_pkt_cnt[0 +: CW]), 256'(1));

        // Randomized traffic with random releases.
        for (int p = 0; p < 250; p++) begin
            q = $urandom_range(0, QN - 1);
            r = $urandom_range(0, 99);
            if (r < 5) begin
                len = 0;
                nb  = $urandom_range(1, 3);
            end else if (r < 8) begin
                len = $urandom_range(65, 127);
                nb  = 2;
            end else if (r < 18) begin
                len = $urandom_range(20, 50);
                nb  = len;
            end else begin
                len = $urandom_range(1, 12);
                nb  = len;
                if (r < 28)      nb = (len > 1) ? len - 1 : 1;
                else if (r < 36) nb = len + 2;
            end
            send_pkt(q, len, nb, 2, 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4), 1);
        end

        idle(4, 0);
        #2;
        chk("scoreboard_drained", 256'(exp_wr.size() + exp_drop.size() + exp_lerr.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
